// File: rtl/pc_pkg.sv
// Shared constants and types for the PC sequencing controller.
package pc_pkg;

  // Next-PC source encodings.
  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_REL = 2'b01;
  localparam logic [1:0] JMP_REG = 2'b10;
  localparam logic [1:0] JMP_ILL = 2'b11;

  // Controller state encoding.
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MUL_WAIT = 2'd1;
  localparam logic [1:0] ST_MUL_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_RUN      = ST_RUN,
    S_MUL_WAIT = ST_MUL_WAIT,
    S_MUL_DONE = ST_MUL_DONE
  } pc_state_e;

  // Sequential instruction step in bytes.
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Bundle of the stall, jump, multiplier and PC lines around the controller.
interface pc_seq_ctrl_if;
  logic        icache_stall;
  logic        dcache_stall;
  logic        is_mul;
  logic [1:0]  jump_signal;
  logic [31:0] jump_addr;
  logic [31:0] read_data;
  logic        mul_ready;
  logic [31:0] pc;
  logic        mul_valid;
  logic        mul_wb;
  logic        pipe_stall;
  logic        illegal_jump;
  logic        mul_timeout;

  // Core side: drives decode/stall information, consumes PC and control.
  modport master (
    output icache_stall, dcache_stall, is_mul, jump_signal, jump_addr,
           read_data, mul_ready,
    input  pc, mul_valid, mul_wb, pipe_stall, illegal_jump, mul_timeout
  );

  // Controller side.
  modport slave (
    input  icache_stall, dcache_stall, is_mul, jump_signal, jump_addr,
           read_data, mul_ready,
    output pc, mul_valid, mul_wb, pipe_stall, illegal_jump, mul_timeout
  );
endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selector for the non-multiply, non-stalled path.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter logic [31:0] TRAP_PC = 32'h0000_0000
) (
  input  logic [31:0] pc,
  input  logic [1:0]  jump_signal,
  input  logic [31:0] jump_addr,
  input  logic [31:0] read_data,
  output logic [31:0] next_pc
);

  // All additions wrap modulo 2^32; only the register target drops bit 0.
  always_comb begin
    next_pc = pc + PC_STEP;
    case (jump_signal)
      JMP_SEQ: next_pc = pc + PC_STEP;
      JMP_REL: next_pc = pc + jump_addr;
      JMP_REG: next_pc = read_data & ~32'd1;
      JMP_ILL: next_pc = TRAP_PC;
      default: next_pc = pc + PC_STEP;
    endcase
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC register and sequencing FSM: jumps, memory stalls and the
// multi-cycle multiplier issue / wait / write-back handshake.
module pc_seq_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC     = 32'h0000_0000,
  parameter int          MUL_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  pc_seq_ctrl_if.slave  bus
);

  localparam logic [7:0] CNT_LAST = 8'(MUL_TIMEOUT - 1);

  logic        mem_stall;
  pc_state_e   state_reg;
  logic [31:0] pc_reg;
  logic [31:0] next_pc;
  logic [7:0]  wait_cnt_reg;
  logic        timeout_reg;

  assign mem_stall = bus.icache_stall | bus.dcache_stall;

  pc_next_mux #(
    .TRAP_PC (TRAP_PC)
  ) u_next_mux (
    .pc          (pc_reg),
    .jump_signal (bus.jump_signal),
    .jump_addr   (bus.jump_addr),
    .read_data   (bus.read_data),
    .next_pc     (next_pc)
  );

  // Single-cycle pulses decoded from the current state; suppressed in reset
  // so no spurious start/write-back can leak out while the FSM is cleared.
  always_comb begin
    bus.mul_valid    = 1'b0;
    bus.illegal_jump = 1'b0;
    bus.mul_wb       = 1'b0;
    if (!rst && !mem_stall) begin
      if (state_reg == S_RUN) begin
        bus.mul_valid    = bus.is_mul;
        bus.illegal_jump = !bus.is_mul && (bus.jump_signal == JMP_ILL);
      end
      bus.mul_wb = (state_reg == S_MUL_DONE);
    end
    bus.pipe_stall = mem_stall || (state_reg != S_RUN) || bus.is_mul;
  end

  assign bus.pc          = pc_reg;
  assign bus.mul_timeout = timeout_reg;

  // PC register, multiplier handshake FSM, wait counter and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      state_reg    <= S_RUN;
      wait_cnt_reg <= 8'd0;
      timeout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_RUN: begin
          if (!mem_stall) begin
            if (bus.is_mul) begin
              state_reg    <= S_MUL_WAIT;
              wait_cnt_reg <= 8'd0;
            end else begin
              pc_reg <= next_pc;
            end
          end
        end
        S_MUL_WAIT: begin
          // Memory stalls are irrelevant here: the PC is already frozen.
          wait_cnt_reg <= wait_cnt_reg + 8'd1;
          if (bus.mul_ready) begin
            state_reg <= S_MUL_DONE;
          end else if (wait_cnt_reg == CNT_LAST) begin
            timeout_reg <= 1'b1;
            state_reg   <= S_MUL_DONE;
          end
        end
        S_MUL_DONE: begin
          if (!mem_stall) begin
            pc_reg    <= pc_reg + PC_STEP;
            state_reg <= S_RUN;
          end
        end
        default: state_reg <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios then random
// traffic, all compared against a behavioural model of the controller.
module tb_pc_seq_ctrl;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC     = 32'h0000_0800;
  localparam int          MUL_TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_seq_ctrl_if bus_if ();

  pc_seq_ctrl #(
    .RESET_PC    (RESET_PC),
    .TRAP_PC     (TRAP_PC),
    .MUL_TIMEOUT (MUL_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: phase 0 = executing, 1 = multiply outstanding,
  // 2 = result to be written back.
  logic [31:0] m_pc;
  int          m_phase;
  int          m_waited;
  logic        m_to;

  // Observed pulse counts / stall coverage for directed scenarios.
  int   n_valid, n_wb, n_ill;
  logic all_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    n_valid = 0; n_wb = 0; n_ill = 0; all_stall = 1'b1;
  endtask

  // One clock: check outputs mid-cycle, clock the edge, advance the model.
  task automatic cycle();
    logic ms, busy_ok;
    logic [31:0] ja, rd;
    #1;
    ms = bus_if.icache_stall | bus_if.dcache_stall;
    if (rst) begin
      chk("valid_in_rst", {31'd0, bus_if.mul_valid}, 32'd0);
      chk("wb_in_rst",    {31'd0, bus_if.mul_wb},    32'd0);
      chk("ill_in_rst",   {31'd0, bus_if.illegal_jump}, 32'd0);
    end else begin
      busy_ok = (m_phase == 0) && !ms;
      chk("pc", bus_if.pc, m_pc);
      chk("timeout", {31'd0, bus_if.mul_timeout}, {31'd0, m_to});
      chk("mul_valid", {31'd0, bus_if.mul_valid}, {31'd0, busy_ok && bus_if.is_mul});
      chk("illegal", {31'd0, bus_if.illegal_jump},
          {31'd0, busy_ok && !bus_if.is_mul && bus_if.jump_signal == 2'b11});
      chk("mul_wb", {31'd0, bus_if.mul_wb}, {31'd0, (m_phase == 2) && !ms});
      chk("pipe_stall", {31'd0, bus_if.pipe_stall},
          {31'd0, ms || (m_phase != 0) || bus_if.is_mul});
    end
    n_valid += int'(bus_if.mul_valid);
    n_wb    += int'(bus_if.mul_wb);
    n_ill   += int'(bus_if.illegal_jump);
    if (!bus_if.pipe_stall) all_stall = 1'b0;
    ja = bus_if.jump_addr;
    rd = bus_if.read_data;
    @(posedge clk);
    if (rst) begin
      m_pc = RESET_PC; m_phase = 0; m_waited = 0; m_to = 1'b0;
    end else if (m_phase == 0) begin
      if (!ms) begin
        if (bus_if.is_mul) begin
          m_phase = 1; m_waited = 0;
        end else begin
          case (bus_if.jump_signal)
            2'b00:   m_pc = m_pc + 32'd4;
            2'b01:   m_pc = m_pc + ja;
            2'b10:   m_pc = {rd[31:1], 1'b0};
            default: m_pc = TRAP_PC;
          endcase
        end
      end
    end else if (m_phase == 1) begin
      m_waited++;
      if (bus_if.mul_ready) m_phase = 2;
      else if (m_waited == MUL_TIMEOUT) begin
        m_to = 1'b1; m_phase = 2;
      end
    end else begin
      if (!ms) begin
        m_pc = m_pc + 32'd4; m_phase = 0;
      end
    end
    #1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    logic [31:0] p;
    bus_if.icache_stall = 1'b0;
    bus_if.dcache_stall = 1'b0;
    bus_if.is_mul       = 1'b0;
    bus_if.jump_signal  = 2'b00;
    bus_if.jump_addr    = 32'd0;
    bus_if.read_data    = 32'd0;
    bus_if.mul_ready    = 1'b0;
    m_pc = 32'hx; m_phase = 0; m_waited = 0; m_to = 1'b0;
    clr_counts();

    // Reset, then three sequential steps.
    rst = 1'b1; cycles(2); rst = 1'b0;
    chk("reset_pc", bus_if.pc, 32'd0);
    chk("reset_to", {31'd0, bus_if.mul_timeout}, 32'd0);
    cycle(); chk("seq_pc4", bus_if.pc, 32'd4);
    cycle(); chk("seq_pc8", bus_if.pc, 32'd8);
    cycle(); chk("seq_pc12", bus_if.pc, 32'd12);

    // Relative and register jumps.
    bus_if.jump_signal = 2'b10; bus_if.read_data = 32'h100; cycle();
    chk("jalr_100", bus_if.pc, 32'h100);
    bus_if.jump_signal = 2'b01; bus_if.jump_addr = 32'hFFFF_FFF0; cycle();
    chk("rel_neg", bus_if.pc, 32'hF0);
    bus_if.jump_signal = 2'b10; bus_if.read_data = 32'h2001; cycle();
    chk("jalr_bit0", bus_if.pc, 32'h2000);
    bus_if.read_data = 32'h40; cycle();
    bus_if.jump_signal = 2'b00;

    // Multiply with mul_ready five cycles after issue.
    clr_counts();
    bus_if.is_mul = 1'b1; cycle(); bus_if.is_mul = 1'b0;
    cycles(4);
    bus_if.mul_ready = 1'b1; cycle(); bus_if.mul_ready = 1'b0;
    chk("mul_wb_after_ready", {31'd0, bus_if.mul_wb}, 32'd1);
    cycle();
    chk("mul_valid_count", n_valid, 32'd1);
    chk("mul_wb_count", n_wb, 32'd1);
    chk("mul_stall_held", {31'd0, all_stall}, 32'd1);
    chk("mul_pc", bus_if.pc, 32'h44);

    // mul_ready coincident with issue must not complete the multiply.
    bus_if.is_mul = 1'b1; bus_if.mul_ready = 1'b1; cycle();
    bus_if.is_mul = 1'b0; bus_if.mul_ready = 1'b0; cycles(2);
    chk("early_ready_ignored", {31'd0, bus_if.mul_wb}, 32'd0);
    bus_if.mul_ready = 1'b1; cycle(); bus_if.mul_ready = 1'b0; cycle();
    chk("early_ready_pc", bus_if.pc, 32'h48);

    // Memory stall in RUN holds the PC.
    p = bus_if.pc;
    bus_if.dcache_stall = 1'b1; cycles(3);
    chk("dstall_hold", bus_if.pc, p);
    bus_if.dcache_stall = 1'b0; cycle();
    chk("dstall_release", bus_if.pc, p + 32'd4);

    // Memory stall on entry to write-back delays mul_wb.
    p = bus_if.pc;
    bus_if.is_mul = 1'b1; cycle(); bus_if.is_mul = 1'b0;
    bus_if.mul_ready = 1'b1; cycle(); bus_if.mul_ready = 1'b0;
    clr_counts();
    bus_if.dcache_stall = 1'b1; cycles(2);
    chk("wb_delayed", n_wb, 32'd0);
    chk("wb_delay_pc", bus_if.pc, p);
    bus_if.dcache_stall = 1'b0; cycle();
    chk("wb_after_stall", n_wb, 32'd1);
    chk("wb_after_stall_pc", bus_if.pc, p + 32'd4);

    // Illegal jump.
    clr_counts();
    bus_if.jump_signal = 2'b11; cycle(); bus_if.jump_signal = 2'b00;
    chk("trap_pc", bus_if.pc, TRAP_PC);
    chk("ill_count", n_ill, 32'd1);

    // Wrap-around.
    bus_if.jump_signal = 2'b10; bus_if.read_data = 32'hFFFF_FFFC; cycle();
    bus_if.jump_signal = 2'b00; cycle();
    chk("wrap_pc", bus_if.pc, 32'd0);

    // Timeout with mul_ready never asserted.
    bus_if.is_mul = 1'b1; cycle(); bus_if.is_mul = 1'b0;
    cycles(MUL_TIMEOUT - 1);
    chk("to_not_yet", {31'd0, bus_if.mul_timeout}, 32'd0);
    cycle();
    chk("to_set", {31'd0, bus_if.mul_timeout}, 32'd1);
    chk("to_wb", {31'd0, bus_if.mul_wb}, 32'd1);
    cycle();
    chk("to_pc", bus_if.pc, 32'd4);
    chk("to_sticky", {31'd0, bus_if.mul_timeout}, 32'd1);

    // Reset during MUL_WAIT aborts; a later mul_ready is ignored.
    bus_if.is_mul = 1'b1; cycle(); bus_if.is_mul = 1'b0; cycles(3);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst_wait_pc", bus_if.pc, RESET_PC);
    chk("rst_clears_to", {31'd0, bus_if.mul_timeout}, 32'd0);
    clr_counts();
    bus_if.mul_ready = 1'b1; cycle(); bus_if.mul_ready = 1'b0; cycle();
    chk("rst_no_wb", n_wb, 32'd0);
    chk("rst_then_seq", bus_if.pc, RESET_PC + 32'd8);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst                 = ($urandom_range(0, 99) == 0);
      bus_if.icache_stall = ($urandom_range(0, 9) == 0);
      bus_if.dcache_stall = ($urandom_range(0, 9) == 0);
      bus_if.is_mul       = ($urandom_range(0, 9) == 0);
      bus_if.mul_ready    = ($urandom_range(0, 6) == 0);
      bus_if.jump_signal  = 2'($urandom_range(0, 3));
      bus_if.jump_addr    = $urandom;
      bus_if.read_data    = $urandom;
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
